mcdt_dist: RTL
==============

# mcdt_dist

Multi-channel data distributor: the receive-side counterpart of the MCDT arbiter. It accepts the single tagged stream (data, valid, 2-bit channel id) that MCDT emits and routes each word into one of three per-channel FIFOs. Each FIFO drains through its own valid/ready output port to a downstream channel consumer. The block sits between the MCDT output and the three channel sinks and provides backpressure to the upstream stream.

## Interface
- `DW`, 32, data width of stream and channel words
- `DEPTH`, 16, per-channel FIFO depth in words; power of two, 2..16
- `clk_i`  in  1  clock; all logic is rising-edge
- `rst_i`  in  1  asynchronous active-high reset
- `in_data_i`  in  DW  stream data word
- `in_val_i`  in  1  stream word valid
- `in_id_i`  in  2  destination channel; 0..2 valid, 3 illegal
- `in_ready_o`  out  1  stream accept; combinational from `in_id_i` and FIFO state
- `chN_data_o` (N=0,1,2)  out  DW  FIFO head word (show-ahead)
- `chN_valid_o` (N=0,1,2)  out  1  FIFO N not empty
- `chN_ready_i` (N=0,1,2)  in  1  consumer takes head word
- `chN_level_o` (N=0,1,2)  out  5  words held in FIFO N, 0..DEPTH
- `drop_cnt_o`  out  8  count of id-3 words dropped, saturating

## Operation
- Accept: `in_val_i && in_ready_o` at a rising edge.
- `in_ready_o`:
  - For id 0..2: `level[id] != DEPTH`.
  - For id 3: always 1.
- An accepted word with id 0..2 is written at the tail of FIFO[id]. An accepted word with id 3 is discarded and `drop_cnt_o` increments.
- `drop_cnt_o` saturates at 255.
- Read: `chN_valid_o && chN_ready_i` at a rising edge pops the head word.
- `chN_ready_i` while `chN_valid_o`=0 has no effect.
- No pass-through:
  - A word written into an empty FIFO is not visible until the next cycle.
  - A full FIFO keeps `in_ready_o`=0 even in a cycle where its consumer pops.
- Level update per FIFO per cycle:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on simultaneous read and write, or on neither.
- Pointers: write and read pointers are `log2(DEPTH)` bits and wrap modulo DEPTH. Fullness and emptiness are decided by the level counter, not by pointer comparison.
- Channels are fully independent. Traffic into channel 0 never stalls a pop on channel 1 or 2.
- `chN_data_o` is undefined-but-stable while `chN_valid_o`=0. The bench must not check it in that state.
- Per-channel ordering is strict FIFO order.

## Timing
- Reset (async assert, deassert synchronous to `clk_i`):
  - All levels = 0.
  - All pointers = 0.
  - `chN_valid_o`=0.
  - `chN_data_o`=0.
  - `drop_cnt_o`=0.
- `in_ready_o` is combinational. After reset it reads 1 for any id.
- Latency:
  - A word accepted at edge k gives `chN_valid_o`=1 after edge k, and that word is at the head.
  - `chN_level_o` updates at the same edge as the write or read.
- Reset mid-operation: all stored words are lost. Outputs return to reset values immediately (asynchronous), and no read or write completes in the reset cycle.
- Throughput: one accept per cycle on the stream, and one pop per cycle per channel, concurrently.

## Configuration
- `MCDT_DIST_DROPCNT_EN` defined:
  - The drop counter is implemented.
  - `drop_cnt_o` behaves as above.
- `MCDT_DIST_DROPCNT_EN` undefined:
  - There is no counter register.
  - `drop_cnt_o` is tied to 0.
  - Id-3 words are still accepted (`in_ready_o`=1) and discarded.

## Test plan
- Reset then 10 writes to id 0 (`0x00C0_0000`..`0x00C0_0009`), with `ch0_ready_i`=0:
  - `ch0_level_o`=10 and `ch0_valid_o`=1.
  - Then set `ch0_ready_i`=1: words pop in order over 10 cycles, and level ends at 0.
- Fill channel 1 with 16 words while its consumer is stalled:
  - `in_ready_o`=0 for id 1 and stays 0 during a cycle with a simultaneous pop.
  - In the same cycle, an id-2 word is accepted and `ch2_level_o`=1.
- Stream 100 words round-robin across ids 0..2 with all consumers always ready:
  - `in_ready_o` is never 0.
  - Each channel receives its 33 or 34 words in order, and no level exceeds 1.
- Send 300 id-3 words:
  - With `MCDT_DIST_DROPCNT_EN`, `drop_cnt_o`=255 (saturated); without it, `drop_cnt_o`=0.
  - In both builds every level stays 0.
- Write 40 words into channel 0 with random consumer stalls:
  - Pointers wrap twice with no loss or duplication, and the data sequence matches the input.
- Assert `rst_i` for one cycle with 5 words in ch0 and 3 in ch2:
  - All levels and valids read 0 immediately.
  - After deassertion, a new word `0xDEAD_BEEF` to id 2 is the head of ch2.

Source files
------------

// File: rtl/mcdt_dist.sv
// mcdt_dist: routes a tagged (data, valid, id) stream into three independent show-ahead FIFOs.
// Optional saturating drop counter for id-3 words is enabled by defining MCDT_DIST_DROPCNT_EN.
module mcdt_dist #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] in_data_i,
    input  logic          in_val_i,
    input  logic [1:0]    in_id_i,
    output logic          in_ready_o,
    output logic [DW-1:0] ch0_data_o,
    output logic          ch0_valid_o,
    input  logic          ch0_ready_i,
    output logic [4:0]    ch0_level_o,
    output logic [DW-1:0] ch1_data_o,
    output logic          ch1_valid_o,
    input  logic          ch1_ready_i,
    output logic [4:0]    ch1_level_o,
    output logic [DW-1:0] ch2_data_o,
    output logic          ch2_valid_o,
    input  logic          ch2_ready_i,
    output logic [4:0]    ch2_level_o,
    output logic [7:0]    drop_cnt_o
);

    localparam int unsigned NCH = 3;
    localparam int unsigned LW  = 5;
    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NCH-1:0] w_ch_ready;
    logic [NCH-1:0] w_full;
    logic [NCH-1:0] w_valid;
    logic [DW-1:0]  w_head  [NCH];
    logic [LW-1:0]  w_level [NCH];

    assign w_ch_ready = {ch2_ready_i, ch1_ready_i, ch0_ready_i};

    // Stream accept: only the addressed FIFO's fullness matters; id 3 is always taken.
    always_comb begin
        in_ready_o = 1'b1;
        case (in_id_i)
            2'd0:    in_ready_o = ~w_full[0];
            2'd1:    in_ready_o = ~w_full[1];
            2'd2:    in_ready_o = ~w_full[2];
            default: in_ready_o = 1'b1;
        endcase
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [DW-1:0] r_mem [DEPTH];
        logic [PW-1:0] r_wr_ptr;
        logic [PW-1:0] r_rd_ptr;
        logic [LW-1:0] r_level;
        logic          r_valid;
        logic          w_wr;
        logic          w_rd;
        logic [LW-1:0] w_level_nxt;

        assign w_full[g] = (r_level == LW'(DEPTH));
        assign w_wr      = in_val_i && (in_id_i == 2'(g)) && !w_full[g];
        assign w_rd      = r_valid && w_ch_ready[g];

        // Level counter decides full/empty; simultaneous read and write leave it unchanged.
        always_comb begin
            w_level_nxt = r_level;
            case ({w_wr, w_rd})
                2'b10:   w_level_nxt = r_level + LW'(1);
                2'b01:   w_level_nxt = r_level - LW'(1);
                default: w_level_nxt = r_level;
            endcase
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    r_mem[PW'(i)] <= '0;
                end
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
                r_valid  <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_mem[r_wr_ptr] <= in_data_i;
                    r_wr_ptr        <= r_wr_ptr + PW'(1);
                end
                if (w_rd) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                r_level <= w_level_nxt;
                r_valid <= (w_level_nxt != '0);
            end
        end

        assign w_head[g]  = r_mem[r_rd_ptr];
        assign w_level[g] = r_level;
        assign w_valid[g] = r_valid;
    end

    assign ch0_data_o  = w_head[0];
    assign ch1_data_o  = w_head[1];
    assign ch2_data_o  = w_head[2];
    assign ch0_valid_o = w_valid[0];
    assign ch1_valid_o = w_valid[1];
    assign ch2_valid_o = w_valid[2];
    assign ch0_level_o = w_level[0];
    assign ch1_level_o = w_level[1];
    assign ch2_level_o = w_level[2];

`ifdef MCDT_DIST_DROPCNT_EN
    logic [7:0] r_drop_cnt;

    // Saturating count of discarded id-3 words.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_drop_cnt <= '0;
        end else if (in_val_i && (in_id_i == 2'd3) && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt_o = r_drop_cnt;
`else
    assign drop_cnt_o = '0;
`endif

endmodule
